// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with single-cycle ops, flags register and an optional shift-add multiplier.
// Define SEQ_ALU_MUL_EN to build the multiplier (opcode 8); without it opcode 8 decodes as illegal.
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       function_select_lines,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] reg_out,
  output logic [WIDTH-1:0] prod_hi,
  output logic [3:0]       SREG
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [3:0] OP_PASS = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_ADC  = 4'd9;
  localparam logic [3:0] SREG_ILLEGAL = 4'b0010;

  logic             done_q, done_d;
  logic [WIDTH-1:0] reg_out_q, reg_out_d;
  logic [3:0]       sreg_q, sreg_d;
  logic             take_alu;

  // ---------------- single-cycle datapath ----------------
  logic [SW-1:0]    sh_amt;
  logic [WIDTH:0]   shl_w, shr_w, add_w, sub_w;
  logic             adc_cin, add_v, sub_v;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v, alu_legal;
  logic [3:0]       alu_sreg;

  assign sh_amt  = B[SW-1:0];
  // One extra bit on the far side of each shift captures the last bit shifted out.
  assign shl_w   = {1'b0, A} << sh_amt;
  assign shr_w   = {A, 1'b0} >> sh_amt;
  assign adc_cin = (function_select_lines == OP_ADC) & sreg_q[0];
  assign add_w   = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, adc_cin};
  assign sub_w   = {1'b0, A} - {1'b0, B};
  assign add_v   = (A[WIDTH-1] == B[WIDTH-1]) && (add_w[WIDTH-1] != A[WIDTH-1]);
  assign sub_v   = (A[WIDTH-1] != B[WIDTH-1]) && (sub_w[WIDTH-1] != A[WIDTH-1]);

  always_comb begin
    alu_res   = '0;
    alu_c     = 1'b0;
    alu_v     = 1'b0;
    alu_legal = 1'b1;
    case (function_select_lines)
      OP_PASS: alu_res = A;
      OP_ADD, OP_ADC: begin
        alu_res = add_w[WIDTH-1:0];
        alu_c   = add_w[WIDTH];
        alu_v   = add_v;
      end
      OP_SUB: begin
        alu_res = sub_w[WIDTH-1:0];
        alu_c   = sub_w[WIDTH];
        alu_v   = sub_v;
      end
      OP_AND: alu_res = A & B;
      OP_OR:  alu_res = A | B;
      OP_XOR: alu_res = A ^ B;
      OP_SHL: begin
        alu_res = shl_w[WIDTH-1:0];
        alu_c   = shl_w[WIDTH];
      end
      OP_SHR: begin
        alu_res = shr_w[WIDTH:1];
        alu_c   = shr_w[0];
      end
      default: alu_legal = 1'b0;
    endcase
    alu_sreg = alu_legal ? {alu_v, alu_res[WIDTH-1], ~|alu_res, alu_c} : SREG_ILLEGAL;
  end

`ifdef SEQ_ALU_MUL_EN
  // ---------------- iterative multiplier ----------------
  localparam logic [3:0]    OP_MUL = 4'd8;
  localparam logic [SW-1:0] LAST   = SW'(WIDTH - 1);

  typedef enum logic {ST_IDLE, ST_MUL_BUSY} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [SW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   prod_hi_q, prod_hi_d;
  logic [WIDTH:0]     step_sum;
  logic [2*WIDTH-1:0] step_prod;

  // prod_q holds {partial sum, remaining multiplier bits}; the LSB selects the add.
  assign step_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign step_prod = {step_sum, prod_q[WIDTH-1:1]};

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    prod_d    = prod_q;
    cnt_d     = cnt_q;
    prod_hi_d = prod_hi_q;
    done_d    = 1'b0;
    reg_out_d = reg_out_q;
    sreg_d    = sreg_q;
    take_alu  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (function_select_lines == OP_MUL) begin
            state_d = ST_MUL_BUSY;
            mcand_d = A;
            prod_d  = {{WIDTH{1'b0}}, B};
            cnt_d   = '0;
          end else begin
            take_alu = 1'b1;
          end
        end
      end
      ST_MUL_BUSY: begin
        prod_d = step_prod;
        cnt_d  = cnt_q + SW'(1);
        if (cnt_q == LAST) begin
          state_d   = ST_IDLE;
          done_d    = 1'b1;
          reg_out_d = step_prod[WIDTH-1:0];
          prod_hi_d = step_prod[2*WIDTH-1:WIDTH];
          sreg_d    = {1'b0, step_prod[WIDTH-1], ~|step_prod, |step_prod[2*WIDTH-1:WIDTH]};
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (take_alu) begin
      done_d    = 1'b1;
      reg_out_d = alu_res;
      prod_hi_d = '0;
      sreg_d    = alu_sreg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      mcand_q   <= '0;
      prod_q    <= '0;
      cnt_q     <= '0;
      prod_hi_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      prod_q    <= prod_d;
      cnt_q     <= cnt_d;
      prod_hi_q <= prod_hi_d;
    end
  end

  assign ready   = (state_q == ST_IDLE);
  assign prod_hi = prod_hi_q;
`else
  always_comb begin
    take_alu  = start;
    done_d    = 1'b0;
    reg_out_d = reg_out_q;
    sreg_d    = sreg_q;
    if (take_alu) begin
      done_d    = 1'b1;
      reg_out_d = alu_res;
      sreg_d    = alu_sreg;
    end
  end

  assign ready   = 1'b1;
  assign prod_hi = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_q    <= 1'b0;
      reg_out_q <= '0;
      sreg_q    <= '0;
    end else begin
      done_q    <= done_d;
      reg_out_q <= reg_out_d;
      sreg_q    <= sreg_d;
    end
  end

  assign done    = done_q;
  assign reg_out = reg_out_q;
  assign SREG    = sreg_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed table-driven bench for seq_alu (WIDTH=8); multiplier checks follow SEQ_ALU_MUL_EN.
module tb_seq_alu;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] fsl;
  logic [7:0] a, b;
  logic       ready, done;
  logic [7:0] reg_out, prod_hi;
  logic [3:0] sreg;

  int checks = 0;
  int errors = 0;

  seq_alu #(.WIDTH(8)) dut (
    .clk                  (clk),
    .reset                (reset),
    .start                (start),
    .function_select_lines(fsl),
    .A                    (a),
    .B                    (b),
    .ready                (ready),
    .done                 (done),
    .reg_out              (reg_out),
    .prod_hi              (prod_hi),
    .SREG                 (sreg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] er;
    logic [3:0] es;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  initial begin
    // SREG = {V,N,Z,C}
    vecs[0]  = '{4'd1,  8'h7F, 8'h7D, 8'hFC, 4'b1100};
    vecs[1]  = '{4'd2,  8'h03, 8'h32, 8'hD1, 4'b0101};
    vecs[2]  = '{4'd1,  8'hFF, 8'h01, 8'h00, 4'b0011};
    vecs[3]  = '{4'd9,  8'h00, 8'h00, 8'h01, 4'b0000};
    vecs[4]  = '{4'd3,  8'h0D, 8'h55, 8'h05, 4'b0000};
    vecs[5]  = '{4'd5,  8'h0D, 8'h55, 8'h58, 4'b0000};
    vecs[6]  = '{4'd6,  8'h81, 8'h01, 8'h02, 4'b0001};
    vecs[7]  = '{4'd7,  8'h81, 8'h08, 8'h81, 4'b0100};
    vecs[8]  = '{4'd0,  8'h80, 8'h11, 8'h80, 4'b0100};
    vecs[9]  = '{4'd4,  8'h0F, 8'h30, 8'h3F, 4'b0000};
    vecs[10] = '{4'd12, 8'h55, 8'hAA, 8'h00, 4'b0010};
    vecs[11] = '{4'd2,  8'h80, 8'h01, 8'h7F, 4'b1000};
    vecs[12] = '{4'd7,  8'h81, 8'h01, 8'h40, 4'b0001};
    vecs[13] = '{4'd9,  8'h01, 8'h01, 8'h03, 4'b0000};
    vecs[14] = '{4'd1,  8'h80, 8'h80, 8'h00, 4'b1011};
    vecs[15] = '{4'd15, 8'hFF, 8'hFF, 8'h00, 4'b0010};
    vecs[16] = '{4'd6,  8'h01, 8'h07, 8'h80, 4'b0100};

    reset = 1'b0; start = 1'b0; fsl = 4'd0; a = 8'd0; b = 8'd0;
    #2 reset = 1'b1;
    #1;
    chk("reset ready", ready, 1);
    chk("reset done", done, 0);
    chk("reset reg_out", reg_out, 0);
    chk("reset prod_hi", prod_hi, 0);
    chk("reset SREG", sreg, 0);
    @(negedge clk) reset = 1'b0;

    // Table issued back-to-back, one op per cycle.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      start = 1'b1; fsl = vecs[i].op; a = vecs[i].a; b = vecs[i].b;
      @(posedge clk); #1;
      chk($sformatf("v%0d done", i), done, 1);
      chk($sformatf("v%0d ready", i), ready, 1);
      chk($sformatf("v%0d reg_out", i), reg_out, vecs[i].er);
      chk($sformatf("v%0d prod_hi", i), prod_hi, 0);
      chk($sformatf("v%0d SREG", i), sreg, vecs[i].es);
      $display("vec %0d op=%0d A=%02h B=%02h -> reg_out=%02h SREG=%04b", i, vecs[i].op,
               vecs[i].a, vecs[i].b, reg_out, sreg);
    end
    @(negedge clk) start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk("idle done", done, 0);
      chk("idle reg_out hold", reg_out, 8'h80);
      chk("idle SREG hold", sreg, 4'b0100);
    end

`ifdef SEQ_ALU_MUL_EN
    @(negedge clk);
    start = 1'b1; fsl = 4'd8; a = 8'd13; b = 8'd85;
    @(posedge clk); #1;
    chk("mul accept ready", ready, 0);
    chk("mul accept done", done, 0);
    @(negedge clk);
    fsl = 4'd1; a = 8'd1; b = 8'd1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k < 8) begin
        chk($sformatf("mul c%0d ready", k), ready, 0);
        chk($sformatf("mul c%0d done", k), done, 0);
        chk($sformatf("mul c%0d reg_out hold", k), reg_out, 8'h80);
      end else begin
        chk("mul done", done, 1);
        chk("mul ready", ready, 1);
        chk("mul reg_out", reg_out, 8'h51);
        chk("mul prod_hi", prod_hi, 8'h04);
        chk("mul SREG", sreg, 4'b0001);
      end
    end
    $display("mul 13*85 -> prod_hi=%02h reg_out=%02h SREG=%04b", prod_hi, reg_out, sreg);
    @(negedge clk) start = 1'b0;
    @(posedge clk); #1;
    chk("mul post done", done, 0);
    chk("mul post prod_hi hold", prod_hi, 8'h04);
`else
    @(negedge clk);
    start = 1'b1; fsl = 4'd8; a = 8'd13; b = 8'd85;
    @(posedge clk); #1;
    chk("op8 illegal done", done, 1);
    chk("op8 illegal ready", ready, 1);
    chk("op8 illegal reg_out", reg_out, 0);
    chk("op8 illegal prod_hi", prod_hi, 0);
    chk("op8 illegal SREG", sreg, 4'b0010);
    $display("op8 (no multiplier) -> reg_out=%02h SREG=%04b", reg_out, sreg);
    @(negedge clk) start = 1'b0;
`endif

    // Nonzero state, then reset three cycles into a multiply.
    @(negedge clk);
    start = 1'b1; fsl = 4'd1; a = 8'd2; b = 8'd3;
    @(posedge clk); #1;
    chk("pre add reg_out", reg_out, 8'h05);
    chk("pre add prod_hi", prod_hi, 0);
    @(negedge clk);
    fsl = 4'd8; a = 8'd13; b = 8'd85;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    repeat (2) @(posedge clk);
`ifdef SEQ_ALU_MUL_EN
    #1 chk("mid mul ready", ready, 0);
`endif
    #2 reset = 1'b1;
    #1;
    chk("abort ready", ready, 1);
    chk("abort done", done, 0);
    chk("abort reg_out", reg_out, 0);
    chk("abort prod_hi", prod_hi, 0);
    chk("abort SREG", sreg, 0);
    $display("reset mid-op -> ready=%0b done=%0b reg_out=%02h SREG=%04b", ready, done, reg_out, sreg);
    @(negedge clk) reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk($sformatf("no done after abort c%0d", k), done, 0);
    end

    // First start accepted on the first edge after reset release.
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; start = 1'b1; fsl = 4'd12; a = 8'h55; b = 8'h0F;
    @(posedge clk); #1;
    chk("first edge done", done, 1);
    chk("first edge reg_out", reg_out, 0);
    chk("first edge SREG", sreg, 4'b0010);
    $display("first start after reset op12 -> done=%0b reg_out=%02h SREG=%04b", done, reg_out, sreg);
    @(negedge clk) start = 1'b0;
    @(posedge clk); #1;
    chk("final done low", done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
